// File: rtl/arc4_pkg.sv
// Shared types and constants for the arc4 key cracker.
// Holds the key-search state encoding and the plaintext acceptance range.
package arc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_RUN,
        ST_LEN,
        ST_CHK,
        ST_NEXT,
        ST_FOUND,
        ST_FAIL
    } crack_state_t;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;
    localparam logic [7:0] LEN_ADDR = 8'd0;

    function automatic logic is_print(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/pt_checker.sv
// Reads the length-prefixed plaintext back from PT memory and
// reports whether every message byte is printable.
module pt_checker
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] rddata,
    output logic [7:0] addr,
    output logic       done,
    output logic       pass
);

    logic       first;
    logic       active;
    logic [8:0] cur;
    logic [7:0] len;
    logic       last;

    // cur is one bit wider than len so a 255-byte message cannot wrap
    assign last = (cur == {1'b0, len});

    always_comb begin
        done = 1'b0;
        pass = 1'b0;
        addr = LEN_ADDR;
        if (first) begin
            if (rddata == 8'd0) begin
                done = 1'b1;
                pass = 1'b1;
            end else begin
                addr = 8'd1;
            end
        end else if (active) begin
            addr = last ? cur[7:0] : cur[7:0] + 8'd1;
            if (!is_print(rddata)) begin
                done = 1'b1;
            end else if (last) begin
                done = 1'b1;
                pass = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first  <= 1'b0;
            active <= 1'b0;
            cur    <= '0;
            len    <= '0;
        end else begin
            first <= start;
            if (first) begin
                len    <= rddata;
                active <= (rddata != 8'd0);
                cur    <= 9'd1;
            end else if (active) begin
                if (done) begin
                    active <= 1'b0;
                end
                cur <= cur + 9'd1;
            end
        end
    end

endmodule

// File: rtl/arc4_crack.sv
// Key-search controller: runs arc4 once per candidate key and accepts
// the first key whose decrypted plaintext is all printable ASCII.
module arc4_crack
    import arc4_pkg::*;
#(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_STEP  = 24'h000001,
    parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    output logic [23:0] key,
    output logic        key_valid,
    output logic        a4_en,
    input  logic        a4_rdy,
    output logic [23:0] a4_key,
    input  logic [7:0]  a4_pt_addr,
    input  logic [7:0]  a4_pt_wrdata,
    input  logic        a4_pt_wren,
    output logic [7:0]  pt_addr,
    output logic [7:0]  pt_wrdata,
    output logic        pt_wren,
    input  logic [7:0]  pt_rddata
);

    crack_state_t state, state_nx;
    logic [23:0]  cand;
    logic [24:0]  sum;
    logic         chk_start;
    logic         chk_done;
    logic         chk_pass;
    logic [7:0]   chk_addr;

    assign sum       = {1'b0, cand} + {1'b0, KEY_STEP};
    assign a4_key    = cand;
    assign rdy       = (state == ST_IDLE);
    assign chk_start = (state == ST_LEN);

    pt_checker u_chk (
        .clk    (clk),
        .rst    (rst),
        .start  (chk_start),
        .rddata (pt_rddata),
        .addr   (chk_addr),
        .done   (chk_done),
        .pass   (chk_pass)
    );

    always_comb begin
        state_nx = state;
        a4_en    = 1'b0;
        unique case (state)
            ST_IDLE:  if (en) state_nx = ST_START;
            ST_START: begin
                if (a4_rdy) begin
                    a4_en    = 1'b1;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY:  if (!a4_rdy) state_nx = ST_RUN;
            ST_RUN:   if (a4_rdy) state_nx = ST_LEN;
            ST_LEN:   state_nx = ST_CHK;
            ST_CHK: begin
                if (chk_done) state_nx = chk_pass ? ST_FOUND : ST_NEXT;
            end
            ST_NEXT: begin
                state_nx = (sum > {1'b0, KEY_MAX}) ? ST_FAIL : ST_START;
            end
            ST_FOUND: state_nx = ST_IDLE;
            ST_FAIL:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // arc4 owns the PT port only while it may be writing
    always_comb begin
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state)
            ST_START, ST_BUSY, ST_RUN: begin
                pt_addr   = a4_pt_addr;
                pt_wrdata = a4_pt_wrdata;
                pt_wren   = a4_pt_wren;
            end
            ST_LEN, ST_CHK: pt_addr = chk_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cand      <= KEY_START;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        cand      <= KEY_START;
                        key_valid <= 1'b0;
                    end
                end
                ST_NEXT: if (state_nx == ST_START) cand <= sum[23:0];
                ST_FOUND: begin
                    key       <= cand;
                    key_valid <= 1'b1;
                end
                ST_FAIL: begin
                    key       <= '0;
                    key_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
